sram_axi_bridge: RTL and testbench

//  Parametrised bridge between the core's valid/ready memory port and the board's async
//  16-bit SRAM (SRAM_* pins). Splits each DATA_W-bit access into DATA_W/SRAM_DW half-word beats.

---
 rtl/sram_bridge_pkg.sv | 33 +++
 rtl/sram_phy_io.sv | 61 ++++++
 rtl/sram_axi_bridge.sv | 213 +++++++++++++++++++++
 tb/tb_sram_axi_bridge.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/sram_bridge_pkg.sv
// Shared types and sizing helpers for the SRAM bridge and its pad block.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package sram_bridge_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      RECOVER,
      RESP
   } state_t;

   // Active-low SRAM strobes, grouped so they move through the pad flops together.
   typedef struct packed {
      logic ce_n;
      logic oe_n;
      logic we_n;
      logic ub_n;
      logic lb_n;
   } sram_ctrl_t;

   localparam sram_ctrl_t CTRL_IDLE = sram_ctrl_t'(5'b11111);

   function automatic int calc_beats(input int data_w, input int sram_dw);
      return data_w / sram_dw;
   endfunction

   // A single-beat bridge still gets a 1-bit beat index so widths never collapse to zero.
   function automatic int calc_beat_w(input int beats);
      return (beats > 1) ? $clog2(beats) : 1;
   endfunction

endpackage

// File: rtl/sram_phy_io.sv
// Pad block: output flops for SRAM address/strobes/write data, DQ tri-state and DQ input path.
// Latency: pad outputs follow the *_nxt inputs by one clock; dq_in is combinational from the pins.
// Backpressure: none; the pads follow whatever the controller commands every cycle.
//
// Ports: clk/rst (sync, active-high); ctrl_nxt, addr_nxt, dq_nxt, dq_oe_nxt = next-cycle pad values;
//        pad_ld = load new address/write data; dq_in = SRAM read data; sram_* = pad pins.
module sram_phy_io
   import sram_bridge_pkg::*;
#(
   parameter int SRAM_DW = 16,
   parameter int SRAM_AW = 20
) (
   input  logic               clk,
   input  logic               rst,
   input  sram_ctrl_t         ctrl_nxt,
   input  logic               pad_ld,
   input  logic [SRAM_AW-1:0] addr_nxt,
   input  logic               dq_oe_nxt,
   input  logic [SRAM_DW-1:0] dq_nxt,
   output logic [SRAM_DW-1:0] dq_in,
   output logic [SRAM_AW-1:0] sram_addr,
   output logic               sram_ce_n,
   output logic               sram_oe_n,
   output logic               sram_we_n,
   output logic               sram_ub_n,
   output logic               sram_lb_n,
   inout  wire  [SRAM_DW-1:0] sram_dq
);

   sram_ctrl_t         ctrl_q;
   logic [SRAM_DW-1:0] dq_q;
   logic               dq_oe_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         ctrl_q    <= CTRL_IDLE;
         sram_addr <= '0;
         dq_q      <= '0;
         dq_oe_q   <= 1'b0;
      end else begin
         ctrl_q  <= ctrl_nxt;
         dq_oe_q <= dq_oe_nxt;
         // Address and data only change when a new beat starts, so they stay put
         // through write recovery and while the bus is idle.
         if (pad_ld) begin
            sram_addr <= addr_nxt;
            dq_q      <= dq_nxt;
         end
      end
   end

   assign sram_ce_n = ctrl_q.ce_n;
   assign sram_oe_n = ctrl_q.oe_n;
   assign sram_we_n = ctrl_q.we_n;
   assign sram_ub_n = ctrl_q.ub_n;
   assign sram_lb_n = ctrl_q.lb_n;

   assign sram_dq = dq_oe_q ? dq_q : {SRAM_DW{1'bz}};
   assign dq_in   = sram_dq;

endmodule

// File: rtl/sram_axi_bridge.sv
// Bridges a valid/ready memory port to a 16-bit async SRAM, one DATA_W access as several half-word beats.
// Latency: read BEATS*(WAIT_CYCLES+1)+1, write enabled_beats*(WAIT_CYCLES+2)+1 cycles from accept to rsp.
// Backpressure: single outstanding request; req_ready low until the response handshake completes.
//
// Ports: ACLK/ARESET (sync, active-high); req_* request channel; rsp_* response channel;
//        SRAM_* board SRAM pins (all outputs registered, DQ driven only during write beats).
module sram_axi_bridge
   import sram_bridge_pkg::*;
#(
   parameter int DATA_W      = 32,
   parameter int SRAM_DW     = 16,
   parameter int SRAM_AW     = 20,
   parameter int WAIT_CYCLES = 1
) (
   input  logic                ACLK,
   input  logic                ARESET,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_we,
   input  logic [31:0]         req_addr,
   input  logic [DATA_W-1:0]   req_wdata,
   input  logic [DATA_W/8-1:0] req_wstrb,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [DATA_W-1:0]   rsp_rdata,
   output logic [SRAM_AW-1:0]  SRAM_ADDR,
   inout  wire  [SRAM_DW-1:0]  SRAM_DQ,
   output logic                SRAM_CE_N,
   output logic                SRAM_OE_N,
   output logic                SRAM_WE_N,
   output logic                SRAM_UB_N,
   output logic                SRAM_LB_N
);

   localparam int BEATS  = calc_beats(DATA_W, SRAM_DW);
   localparam int BEAT_W = calc_beat_w(BEATS);
   localparam int STRB_W = DATA_W / 8;
   localparam int LANES  = SRAM_DW / 8;
   localparam int OFF_W  = $clog2(STRB_W);
   localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES);

   state_t              state, state_nxt;
   logic [BEAT_W-1:0]   beat, beat_nxt;
   logic [3:0]          wait_cnt, wait_nxt;
   logic                lat_we;
   logic [SRAM_AW-1:0]  lat_base;
   logic [DATA_W-1:0]   lat_wdata;
   logic [STRB_W-1:0]   lat_wstrb;

   logic                acc;
   logic [BEAT_W:0]     first_hit, next_hit;
   logic                cur_we;
   logic [SRAM_AW-1:0]  cur_base, req_base;
   logic [DATA_W-1:0]   cur_wdata;
   logic [STRB_W-1:0]   cur_wstrb;
   logic [LANES-1:0]    sel_strb;
   sram_ctrl_t          ctrl_nxt;
   logic                pad_ld, dq_oe_nxt;
   logic [SRAM_AW-1:0]  addr_nxt;
   logic [SRAM_DW-1:0]  dq_nxt, dq_in;

   // Lowest enabled beat at or above 'from'; MSB of the result flags that one exists.
   // Reads use every beat, writes skip beats whose byte strobes are all clear.
   function automatic logic [BEAT_W:0] find_beat(input logic we, input logic [STRB_W-1:0] strb,
                                                 input int from);
      logic [BEAT_W:0] r;
      r = '0;
      for (int b = BEATS - 1; b >= 0; b--) begin
         if (b >= from && (!we || strb[b*LANES +: LANES] != '0))
            r = {1'b1, BEAT_W'(b)};
      end
      return r;
   endfunction

   assign acc       = req_valid && req_ready;
   // Word address of beat 0; bits above SRAM_AW wrap away in the cast.
   assign req_base  = SRAM_AW'((req_addr >> OFF_W) << BEAT_W);
   assign first_hit = find_beat(req_we, req_wstrb, 0);
   assign next_hit  = find_beat(lat_we, lat_wstrb, int'(beat) + 1);

   // Request fields are not latched yet on the accept cycle, so pad values come straight from the port.
   assign cur_we    = acc ? req_we    : lat_we;
   assign cur_base  = acc ? req_base  : lat_base;
   assign cur_wdata = acc ? req_wdata : lat_wdata;
   assign cur_wstrb = acc ? req_wstrb : lat_wstrb;

   always_comb begin
      state_nxt = state;
      beat_nxt  = beat;
      wait_nxt  = wait_cnt;
      case (state)
         IDLE: begin
            if (acc) begin
               if (first_hit[BEAT_W]) begin
                  state_nxt = ACCESS;
                  beat_nxt  = first_hit[BEAT_W-1:0];
                  wait_nxt  = '0;
               end else begin
                  state_nxt = RESP;
               end
            end
         end
         ACCESS: begin
            if (wait_cnt != WAIT_LAST) begin
               wait_nxt = wait_cnt + 4'd1;
            end else if (lat_we) begin
               state_nxt = RECOVER;
            end else if (next_hit[BEAT_W]) begin
               state_nxt = ACCESS;
               beat_nxt  = next_hit[BEAT_W-1:0];
               wait_nxt  = '0;
            end else begin
               state_nxt = RESP;
            end
         end
         RECOVER: begin
            if (next_hit[BEAT_W]) begin
               state_nxt = ACCESS;
               beat_nxt  = next_hit[BEAT_W-1:0];
               wait_nxt  = '0;
            end else begin
               state_nxt = RESP;
            end
         end
         RESP: begin
            if (rsp_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Pad command for the cycle after this edge, so SRAM pins line up with the state register.
   always_comb begin
      ctrl_nxt  = CTRL_IDLE;
      dq_oe_nxt = 1'b0;
      sel_strb  = cur_wstrb[beat_nxt*LANES +: LANES];
      pad_ld    = (state_nxt == ACCESS);
      addr_nxt  = cur_base | SRAM_AW'(beat_nxt);
      dq_nxt    = cur_wdata[beat_nxt*SRAM_DW +: SRAM_DW];
      if (state_nxt == ACCESS) begin
         ctrl_nxt.ce_n = 1'b0;
         if (cur_we) begin
            ctrl_nxt.we_n = 1'b0;
            ctrl_nxt.ub_n = ~sel_strb[1];
            ctrl_nxt.lb_n = ~sel_strb[0];
            dq_oe_nxt     = 1'b1;
         end else begin
            ctrl_nxt.oe_n = 1'b0;
            ctrl_nxt.ub_n = 1'b0;
            ctrl_nxt.lb_n = 1'b0;
         end
      end else if (state_nxt == RECOVER) begin
         // WE_N rises while CE_N, lanes, address and data hold for one cycle.
         ctrl_nxt.ce_n = 1'b0;
         ctrl_nxt.ub_n = ~sel_strb[1];
         ctrl_nxt.lb_n = ~sel_strb[0];
         dq_oe_nxt     = 1'b1;
      end
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         state     <= IDLE;
         beat      <= '0;
         wait_cnt  <= '0;
         req_ready <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         lat_we    <= 1'b0;
         lat_base  <= '0;
         lat_wdata <= '0;
         lat_wstrb <= '0;
      end else begin
         state     <= state_nxt;
         beat      <= beat_nxt;
         wait_cnt  <= wait_nxt;
         req_ready <= (state_nxt == IDLE);
         rsp_valid <= (state_nxt == RESP);
         if (acc) begin
            lat_we    <= req_we;
            lat_base  <= req_base;
            lat_wdata <= req_wdata;
            lat_wstrb <= req_wstrb;
            rsp_rdata <= '0;
         end
         // Read data is taken on the final wait cycle of each beat.
         if (state == ACCESS && !lat_we && wait_cnt == WAIT_LAST)
            rsp_rdata[beat*SRAM_DW +: SRAM_DW] <= dq_in;
      end
   end

   sram_phy_io #(
      .SRAM_DW (SRAM_DW),
      .SRAM_AW (SRAM_AW)
   ) u_phy (
      .clk       (ACLK),
      .rst       (ARESET),
      .ctrl_nxt  (ctrl_nxt),
      .pad_ld    (pad_ld),
      .addr_nxt  (addr_nxt),
      .dq_oe_nxt (dq_oe_nxt),
      .dq_nxt    (dq_nxt),
      .dq_in     (dq_in),
      .sram_addr (SRAM_ADDR),
      .sram_ce_n (SRAM_CE_N),
      .sram_oe_n (SRAM_OE_N),
      .sram_we_n (SRAM_WE_N),
      .sram_ub_n (SRAM_UB_N),
      .sram_lb_n (SRAM_LB_N),
      .sram_dq   (SRAM_DQ)
   );

endmodule

// File: tb/tb_sram_axi_bridge.sv
// Bench for sram_axi_bridge: async SRAM pin model, directed cases and random traffic vs. a reference model.
// Latency: n/a.
// Backpressure: exercised via randomly delayed rsp_ready and requests presented while busy.
module tb_sram_axi_bridge;

   localparam int WAIT = 1;

   logic        ACLK = 1'b0;
   logic        ARESET;
   logic        req_valid, req_ready, req_we;
   logic [31:0] req_addr, req_wdata;
   logic [3:0]  req_wstrb;
   logic        rsp_valid, rsp_ready;
   logic [31:0] rsp_rdata;
   logic [19:0] SRAM_ADDR;
   wire  [15:0] SRAM_DQ;
   logic        SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N;

   sram_axi_bridge #(
      .DATA_W(32), .SRAM_DW(16), .SRAM_AW(20), .WAIT_CYCLES(WAIT)
   ) dut (
      .ACLK(ACLK), .ARESET(ARESET),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .SRAM_ADDR(SRAM_ADDR), .SRAM_DQ(SRAM_DQ),
      .SRAM_CE_N(SRAM_CE_N), .SRAM_OE_N(SRAM_OE_N), .SRAM_WE_N(SRAM_WE_N),
      .SRAM_UB_N(SRAM_UB_N), .SRAM_LB_N(SRAM_LB_N)
   );

   always #5 ACLK = ~ACLK;

   // ---------------- SRAM pin model ----------------
   logic [15:0] mem [0:(1<<20)-1];
   assign SRAM_DQ = (!SRAM_CE_N && !SRAM_OE_N && SRAM_WE_N) ? mem[SRAM_ADDR] : 16'hzzzz;
   always @(posedge ACLK) begin
      if (!SRAM_CE_N && !SRAM_WE_N) begin
         if (!SRAM_LB_N) mem[SRAM_ADDR][7:0]  <= SRAM_DQ[7:0];
         if (!SRAM_UB_N) mem[SRAM_ADDR][15:8] <= SRAM_DQ[15:8];
      end
   end

   // ---------------- reference model state ----------------
   logic [15:0] ref_mem [int];
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          acc_cyc;
   logic        busy = 1'b0;
   int          exp_lat;
   logic [31:0] exp_rdata;
   int          ce_cnt, we_cnt;
   logic        wub, wlb;
   logic [31:0] last_rdata;

   always @(posedge ACLK) cyc <= cyc + 1;

   function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
      end
   endfunction

   function automatic logic [15:0] ref_rd(input int w);
      return ref_mem.exists(w) ? ref_mem[w] : 16'h0;
   endfunction

   // Per-cycle compare against the model for the transaction in flight.
   always @(negedge ACLK) begin
      chk("oe_we_both_low", {63'd0, (!SRAM_OE_N && !SRAM_WE_N)}, 64'd0);
      if (busy) begin
         chk("req_ready_while_busy", {63'd0, req_ready}, 64'd0);
         chk("rsp_valid_timing", {63'd0, rsp_valid}, {63'd0, ((cyc - acc_cyc + 1) >= exp_lat)});
         if (rsp_valid) chk("rsp_rdata", {32'd0, rsp_rdata}, {32'd0, exp_rdata});
         if (!SRAM_CE_N) ce_cnt++;
         if (!SRAM_WE_N) begin
            we_cnt++;
            wub = SRAM_UB_N;
            wlb = SRAM_LB_N;
         end
      end
   end

   task automatic do_txn(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [3:0] ws, input int hold, input logic poke, output int lat);
      int word0, en, l_lat, l_ce, l_we;
      logic [31:0] l_rd;
      logic [15:0] v;
      bit got;
      word0 = int'(((addr >> 2) << 1) & 32'h000F_FFFF);
      en = 0;
      for (int b = 0; b < 2; b++) if (!we || ws[2*b +: 2] != 2'b00) en++;
      l_lat = we ? en * (WAIT + 2) + 1 : 2 * (WAIT + 1) + 1;
      l_ce  = we ? en * (WAIT + 2) : 2 * (WAIT + 1);
      l_we  = we ? en * (WAIT + 1) : 0;
      l_rd  = we ? 32'h0 : {ref_rd(word0 + 1), ref_rd(word0)};
      if (we) begin
         for (int i = 0; i < 4; i++) begin
            if (ws[i]) begin
               v = ref_rd(word0 + i / 2);
               if (i % 2 == 1) v[15:8] = wd[8*i +: 8];
               else            v[7:0]  = wd[8*i +: 8];
               ref_mem[word0 + i / 2] = v;
            end
         end
      end
      lat = -1;
      @(posedge ACLK); #1;
      req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd; req_wstrb = ws;
      got = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge ACLK);
         if (req_ready) begin got = 1'b1; break; end
      end
      if (!got) begin
         chk("accept_timeout", 64'd0, 64'd1);
         req_valid = 1'b0;
         return;
      end
      acc_cyc = cyc + 1;
      @(posedge ACLK); #1;
      req_valid = poke;
      exp_lat = l_lat; exp_rdata = l_rd;
      ce_cnt = 0; we_cnt = 0; wub = 1'b0; wlb = 1'b1;
      rsp_ready = (hold == 0);
      busy = 1'b1;
      for (int i = 0; i < 200; i++) begin
         @(negedge ACLK);
         if (rsp_valid) begin lat = cyc - acc_cyc + 1; last_rdata = rsp_rdata; break; end
      end
      if (lat < 0) chk("rsp_timeout", 64'd0, 64'd1);
      if (hold > 0) begin
         repeat (hold) @(negedge ACLK);
         @(posedge ACLK); #1;
         rsp_ready = 1'b1;
         @(negedge ACLK);
      end
      @(posedge ACLK); #1;
      busy = 1'b0; rsp_ready = 1'b0; req_valid = 1'b0;
      @(negedge ACLK);
      chk("rsp_valid_after_hs", {63'd0, rsp_valid}, 64'd0);
      chk("req_ready_after_hs", {63'd0, req_ready}, 64'd1);
      chk("latency", 64'(lat), 64'(l_lat));
      chk("ce_cycles", 64'(ce_cnt), 64'(l_ce));
      chk("we_cycles", 64'(we_cnt), 64'(l_we));
   endtask

   initial begin
      int lat;
      logic [31:0] a;
      for (int i = 0; i < (1 << 20); i++) mem[i] = 16'h0;
      ARESET = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
      req_wdata = '0; req_wstrb = '0; rsp_ready = 1'b0;
      repeat (3) @(posedge ACLK);
      @(negedge ACLK);
      chk("rst_req_ready", {63'd0, req_ready}, 64'd0);
      chk("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
      chk("rst_rsp_rdata", {32'd0, rsp_rdata}, 64'd0);
      chk("rst_ctrl_n", {59'd0, SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N}, 64'h1F);
      chk("rst_addr", {44'd0, SRAM_ADDR}, 64'd0);
      @(posedge ACLK); #1 ARESET = 1'b0;
      repeat (2) @(posedge ACLK);

      // 1: full write
      do_txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 1'b0, lat);
      chk("t1_latency", 64'(lat), 64'd7);
      chk("t1_word8", {48'd0, mem[8]}, 64'hBEEF);
      chk("t1_word9", {48'd0, mem[9]}, 64'hDEAD);
      // 2: read back
      do_txn(1'b0, 32'h10, 32'h0, 4'h0, 0, 1'b0, lat);
      chk("t2_latency", 64'(lat), 64'd5);
      chk("t2_rdata", {32'd0, last_rdata}, 64'hDEADBEEF);
      chk("t2_we_cycles", 64'(we_cnt), 64'd0);
      // 3: single byte in upper beat
      do_txn(1'b1, 32'h10, 32'h11223344, 4'h4, 0, 1'b0, lat);
      chk("t3_latency", 64'(lat), 64'd4);
      chk("t3_ub_lb", {62'd0, wub, wlb}, 64'b10);
      chk("t3_word9", {48'd0, mem[9]}, 64'hDE22);
      chk("t3_word8", {48'd0, mem[8]}, 64'hBEEF);
      // 4: empty write
      do_txn(1'b1, 32'h20, 32'h55555555, 4'h0, 0, 1'b0, lat);
      chk("t4_latency", 64'(lat), 64'd1);
      chk("t4_ce_cycles", 64'(ce_cnt), 64'd0);
      // 5: held response with a competing request
      do_txn(1'b0, 32'h10, 32'h0, 4'h0, 10, 1'b1, lat);
      chk("t5_rdata", {32'd0, last_rdata}, 64'hDE22BEEF);
      // 6: reset during beat 0 of a write
      @(posedge ACLK); #1;
      req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h40; req_wdata = 32'hCAFEF00D; req_wstrb = 4'hF;
      @(negedge ACLK);
      chk("t6_accept_ready", {63'd0, req_ready}, 64'd1);
      @(posedge ACLK); #1 req_valid = 1'b0;
      @(negedge ACLK);
      chk("t6_beat0_we", {63'd0, SRAM_WE_N}, 64'd0);
      @(posedge ACLK); #1 ARESET = 1'b1;
      @(posedge ACLK);
      @(negedge ACLK);
      chk("t6_ctrl_n", {59'd0, SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N}, 64'h1F);
      chk("t6_rsp_valid", {63'd0, rsp_valid}, 64'd0);
      chk("t6_req_ready_in_rst", {63'd0, req_ready}, 64'd0);
      @(posedge ACLK); #1 ARESET = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge ACLK);
         chk("t6_no_rsp", {63'd0, rsp_valid}, 64'd0);
         if (i > 0) chk("t6_ready_back", {63'd0, req_ready}, 64'd1);
      end
      ref_mem[32'h20] = 16'hF00D;
      chk("t6_partial_word", {48'd0, mem[32'h20]}, 64'hF00D);
      do_txn(1'b0, 32'h40, 32'h0, 4'h0, 0, 1'b0, lat);
      chk("t6_readback", {32'd0, last_rdata}, 64'h0000F00D);

      // Random traffic over a small address pool with wrapping upper bits.
      for (int n = 0; n < 200; n++) begin
         a = ($urandom & 32'hFFE0_0000) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
         do_txn(1'($urandom % 2), a, $urandom, 4'($urandom_range(0, 15)),
                $urandom_range(0, 3), 1'($urandom % 2), lat);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
